vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Produces the raster scan (hcount/vcount) consumed by every DrawBlock*
//  sprite reader, plus sync and blank outputs. Takes back the merged 8-bit
//  sprite pixel and drives the VGA output. Delays sync/blank by the sprite
//  readers' fixed latency so pixel and sync leave in the same cycle.
//  Sits at top level between the DrawBlock* pixel mux and the DAC/pins.
// PARAMETERS
//  H_ACTIVE  800  visible pixels per line
//  H_FP      56   horizontal front porch (clocks)
//  H_SYNC    120  hsync pulse width (clocks)
//  H_BP      64   horizontal back porch (clocks); H_TOTAL = 1040
//  V_ACTIVE  600  visible lines per frame
//  V_FP      37   vertical front porch (lines)
//  V_SYNC    6    vsync pulse width (lines)
//  V_BP      23   vertical back porch (lines); V_TOTAL = 666
//  HS_POL    1    hsync active level
//  VS_POL    1    vsync active level
//  PIX_LAT   2    cycles from hcount/vcount to valid pixel_in (>=1)
// PORTS
//  vclk        in   1   pixel clock, all logic rising-edge
//  rst         in   1   asynchronous reset, active-high
//  en          in   1   advance enable; 0 stalls every register
//  pixel_in    in   8   merged sprite pixel for counters PIX_LAT cycles ago
//  hcount      out  11  current column, 0..H_TOTAL-1
//  vcount      out  10  current line, 0..V_TOTAL-1
//  frame_start out  1   high while hcount==0 && vcount==0 && en
//  line_start  out  1   high while hcount==0 && en
//  hsync       out  1   delayed horizontal sync, polarity HS_POL
//  vsync       out  1   delayed vertical sync, polarity VS_POL
//  blank       out  1   delayed blanking, 1 = outside active area
//  rgb_out     out  8   pixel to DAC, 0 while blanked
// BEHAVIOUR
//  - Reset (async, any time): hcount=0, vcount=0, all delay stages blank=1,
//    syncs=~POL, rgb_out=0. Scan restarts from (0,0); no partial frame kept.
//  - en=1 per edge: hcount+1. At hcount==H_TOTAL-1 hcount->0 and vcount+1.
//    At (H_TOTAL-1, V_TOTAL-1) both wrap to 0 on the same edge.
//  - en=0: counters, delay line and rgb_out hold; frame/line_start = 0.
//  - Raw decode (combinational from counters):
//    blank_r = hcount>=H_ACTIVE || vcount>=V_ACTIVE
//    hs_r active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (856..975)
//    vs_r active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (637..642)
//    vs_r is line-based; it changes only on the hcount wrap edge.
//  - Delay line: {blank_r,hs_r,vs_r} go through a PIX_LAT-deep shift register,
//    then one output register. Output register loads rgb_out =
//    delayed blank ? 8'h00 : pixel_in, with hsync/vsync/blank on the same edge.
//  - Latency: counters in cycle t -> hsync/vsync/blank/rgb_out valid in
//    cycle t+PIX_LAT+1 (counted in enabled cycles).
//  - Width check: H_TOTAL<=2048 and V_TOTAL<=1024, checked at elaboration.
//    Any violation is a synthesis error.
// TESTING
//  1 rst pulse mid-line (hcount=500) -> same cycle hcount=0,vcount=0,blank=1,
//    rgb_out=0,hsync=vsync=0.
//  2 en=1 free run -> hcount 1039->0 with vcount+1; (1039,665)->(0,0);
//    frame_start period 692640 clocks; line_start period 1040.
//  3 pixel_in=8'hF0 constant -> rgb_out=F0 exactly when blank=0.
//    Cycle t with (799,y<600) gives F0 at t+3; (800,y) gives 00 at t+3.
//  4 hsync high 120 clocks, rising 3 cycles after hcount==856.
//    vsync high 6 lines, rising 3 cycles after (0,637).
//  5 en toggled 1/0 alternately -> counters and outputs change only on en=1
//    edges; the sequence equals the free run with duplicates removed.
//  6 PIX_LAT=1 build, pixel_in=hcount[7:0] -> rgb_out(t+2) equals
//    hcount(t)[7:0] in the active area.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster counter and sync/blank generator. Sync and blank are delayed so they
// leave in the same cycle as the sprite pixel that matches their position.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIX_LAT  = 2
) (
  input  logic        vclk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  pixel_in,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        frame_start,
  output logic        line_start,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [7:0]  rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Compare in one extra bit so a sync ending exactly at the counter limit still works.
  localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIX_LAT < 1) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter width or PIX_LAT < 1");
  end

  logic [10:0] hcount_reg;
  logic [9:0]  vcount_reg;
  logic [11:0] h_ext;
  logic [10:0] v_ext;
  logic [2:0]  raw_decode;
  logic [2:0]  dly_out;
  logic        hsync_reg;
  logic        vsync_reg;
  logic        blank_reg;
  logic [7:0]  rgb_reg;

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      hcount_reg <= '0;
      vcount_reg <= '0;
    end else if (en) begin
      if (hcount_reg == H_LAST) begin
        hcount_reg <= '0;
        vcount_reg <= (vcount_reg == V_LAST) ? '0 : vcount_reg + 10'd1;
      end else begin
        hcount_reg <= hcount_reg + 11'd1;
      end
    end
  end

  // raw_decode = {blank, hsync active, vsync active}
  always_comb begin
    h_ext         = {1'b0, hcount_reg};
    v_ext         = {1'b0, vcount_reg};
    raw_decode[2] = (h_ext >= H_VIS) || (v_ext >= V_VIS);
    raw_decode[1] = (h_ext >= HS_BEG) && (h_ext < HS_END);
    raw_decode[0] = (v_ext >= VS_BEG) && (v_ext < VS_END);
  end

  for (genvar gi = 0; gi < PIX_LAT; gi++) begin : g_dly
    logic [2:0] stage_reg;
    logic [2:0] stage_in;
    if (gi == 0) begin : g_first
      assign stage_in = raw_decode;
    end else begin : g_rest
      assign stage_in = g_dly[gi-1].stage_reg;
    end
    always_ff @(posedge vclk or posedge rst) begin
      if (rst)     stage_reg <= 3'b100;
      else if (en) stage_reg <= stage_in;
    end
  end

  assign dly_out = g_dly[PIX_LAT-1].stage_reg;

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      blank_reg <= 1'b1;
      hsync_reg <= ~HS_POL;
      vsync_reg <= ~VS_POL;
      rgb_reg   <= 8'h00;
    end else if (en) begin
      blank_reg <= dly_out[2];
      hsync_reg <= dly_out[1] ? HS_POL : ~HS_POL;
      vsync_reg <= dly_out[0] ? VS_POL : ~VS_POL;
      rgb_reg   <= dly_out[2] ? 8'h00 : pixel_in;
    end
  end

  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign line_start  = en && (hcount_reg == 11'd0);
  assign frame_start = en && (hcount_reg == 11'd0) && (vcount_reg == 10'd0);
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign blank       = blank_reg;
  assign rgb_out     = rgb_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a shrunken raster; expected outputs
// come from the number of enabled edges since reset.
module tb_vga_timing_gen;

  localparam int HA = 20, HF = 3, HS = 4, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        vclk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  pixel_in;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        frame_start, line_start, hsync, vsync, blank;
  logic [7:0]  rgb_out;

  int total = 0;
  int bad   = 0;
  int steps;
  logic [7:0] last_pix;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(LAT)
  ) dut (
    .vclk(vclk), .rst(rst), .en(en), .pixel_in(pixel_in),
    .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .line_start(line_start),
    .hsync(hsync), .vsync(vsync), .blank(blank), .rgb_out(rgb_out)
  );

  always #5 vclk = ~vclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (steps=%0d)", tag, got, exp, steps);
    end
  endtask

  // Counters sit at position 'steps'; the output register reflects the raster
  // position LAT+1 steps back and the pixel captured on the latest enabled edge.
  task automatic check_outputs();
    int p, q, h, v;
    logic eb, ehs, evs;
    logic [7:0] ergb;
    p = steps % FRAME;
    check("hcount", 32'(hcount), 32'(p % HT));
    check("vcount", 32'(vcount), 32'(p / HT));
    q = steps - 1 - LAT;
    if (q < 0) begin
      eb = 1'b1; ehs = 1'b0; evs = 1'b0; ergb = 8'h00;
    end else begin
      h    = (q % FRAME) % HT;
      v    = (q % FRAME) / HT;
      eb   = (h >= HA) || (v >= VA);
      ehs  = (h >= HA + HF) && (h < HA + HF + HS);
      evs  = (v >= VA + VF) && (v < VA + VF + VS);
      ergb = eb ? 8'h00 : last_pix;
    end
    check("blank", 32'(blank), 32'(eb));
    check("hsync", 32'(hsync), 32'(ehs));
    check("vsync", 32'(vsync), 32'(evs));
    check("rgb_out", 32'(rgb_out), 32'(ergb));
  endtask

  task automatic check_starts();
    int p;
    p = steps % FRAME;
    check("line_start", 32'(line_start), 32'(en && (p % HT == 0)));
    check("frame_start", 32'(frame_start), 32'(en && (p == 0)));
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    pixel_in = 8'h00;
    steps    = 0;
    last_pix = 8'h00;
    repeat (2) @(posedge vclk);
    #1 check_outputs();
    rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      en       = (c >= 2000 && c < 2500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      pixel_in = 8'($urandom);
      #1 check_starts();
      @(posedge vclk);
      if (en) begin
        steps++;
        last_pix = pixel_in;
      end
      #1 check_outputs();
      if (c == 1700) begin
        // asynchronous reset mid-scan must clear everything without a clock edge
        #1 rst = 1'b1;
        steps = 0;
        #1 check_outputs();
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
